// File: rtl/sqrt_controller.sv
// Sequential integer square root: two radicand bits per cycle,
// restoring digit recurrence, N/2 iterations per operation.
module sqrt_controller #(
  parameter int N = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N-1:0]     radicand_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N/2-1:0]   root_o,
  output logic [N/2:0]     rem_o
);

  localparam int H  = N / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rad_q, rad_d;
  logic [H+1:0]    rem_q, rem_d;
  logic [H-1:0]    root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [H+1:0]    shifted;
  logic [H+1:0]    trial;

  // rem <= 2*root bounds shifted below 2^(H+2), so dropping
  // the top two bits of rem here never loses information.
  assign shifted = {rem_q[H-1:0], rad_q[N-1:N-2]};
  assign trial   = {root_q, 2'b01};

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rad_d   = radicand_i;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(H - 1);
          state_d = ITER;
        end
      end
      ITER: begin
        rad_d = {rad_q[N-3:0], 2'b00};
        if (shifted >= trial) begin
          rem_d  = shifted - trial;
          root_d = {root_q[H-2:0], 1'b1};
        end else begin
          rem_d  = shifted;
          root_d = {root_q[H-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == ITER);
  assign done_o = (state_q == DONE);
  assign root_o = root_q;
  assign rem_o  = rem_q[H:0];

endmodule

// File: tb/tb_sqrt_controller.sv
// Directed vectors, abort/restart corner cases and a
// back-to-back sweep against an integer square-root model.
module tb_sqrt_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] radicand;
  logic        busy;
  logic        done;
  logic [7:0]  root;
  logic [8:0]  rem;

  int checks;
  int failures;

  sqrt_controller #(.N(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .radicand_i (radicand),
    .busy_o     (busy),
    .done_o     (done),
    .root_o     (root),
    .rem_o      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rad;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] val,
                        output int lat,
                        output int bcnt);
    start    = 1'b1;
    radicand = val;
    tick();
    start    = 1'b0;
    radicand = 16'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, npulse;
    int vals[$];
    int idx, cyc, last, wt;
    logic [7:0] r_at;
    logic [8:0] m_at;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    radicand = '0;
    rst_n    = 1'b0;

    vecs[0]  = '{16'd0,     8'd0,   9'd0};
    vecs[1]  = '{16'd144,   8'd12,  9'd0};
    vecs[2]  = '{16'd17,    8'd4,   9'd1};
    vecs[3]  = '{16'd65535, 8'd255, 9'd510};
    vecs[4]  = '{16'd1,     8'd1,   9'd0};
    vecs[5]  = '{16'd2,     8'd1,   9'd1};
    vecs[6]  = '{16'd3,     8'd1,   9'd2};
    vecs[7]  = '{16'd4,     8'd2,   9'd0};
    vecs[8]  = '{16'd15,    8'd3,   9'd6};
    vecs[9]  = '{16'd16,    8'd4,   9'd0};
    vecs[10] = '{16'd50,    8'd7,   9'd1};
    vecs[11] = '{16'd65025, 8'd255, 9'd0};
    vecs[12] = '{16'd65024, 8'd254, 9'd508};
    vecs[13] = '{16'd100,   8'd10,  9'd0};
    vecs[14] = '{16'd255,   8'd15,  9'd30};
    vecs[15] = '{16'd256,   8'd16,  9'd0};
    vecs[16] = '{16'd1000,  8'd31,  9'd39};

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_root", 32'(root), 32'd0);
    chk("rst_rem",  32'(rem),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].rad, lat, bcnt);
      chk("vec_latency", 32'(lat), 32'd8);
      chk("vec_busy_cycles", 32'(bcnt), 32'd8);
      chk("vec_root", 32'(root), 32'(vecs[i].root));
      chk("vec_rem", 32'(rem), 32'(vecs[i].rem));
      tick();
      chk("vec_done_pulse", 32'(done), 32'd0);
      chk("vec_hold_root", 32'(root), 32'(vecs[i].root));
      chk("vec_hold_rem", 32'(rem), 32'(vecs[i].rem));
    end

    // restart attempt while iterating must be ignored
    start    = 1'b1;
    radicand = 16'd100;
    tick();
    start    = 1'b0;
    tick();
    start    = 1'b1;
    radicand = 16'd9;
    tick();
    tick();
    start    = 1'b0;
    npulse   = 0;
    r_at     = '0;
    m_at     = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        npulse++;
        r_at = root;
        m_at = rem;
      end
      tick();
    end
    chk("restart_pulses", 32'(npulse), 32'd1);
    chk("restart_root", 32'(r_at), 32'd10);
    chk("restart_rem", 32'(m_at), 32'd0);

    // abort in the 4th iteration cycle
    start    = 1'b1;
    radicand = 16'd200;
    tick();
    start    = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_root", 32'(root), 32'd0);
    chk("abort_rem",  32'(rem),  32'd0);
    tick();
    #3;
    rst_n  = 1'b1;
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 32'd0);
    run_op(16'd50, lat, bcnt);
    chk("post_abort_lat", 32'(lat), 32'd8);
    chk("post_abort_root", 32'(root), 32'd7);
    chk("post_abort_rem", 32'(rem), 32'd1);
    tick();

    // back-to-back sweep, start held high
    for (int v = 0; v < 1536; v++) vals.push_back(v);
    for (int v = 64024; v < 65536; v++) vals.push_back(v);
    idx      = 0;
    cyc      = 0;
    last     = -1;
    wt       = 0;
    start    = 1'b1;
    radicand = 16'(vals[0]);
    while (idx < vals.size()) begin
      tick();
      cyc++;
      if (done) begin
        chk("sweep_root", 32'(root), 32'(isqrt(vals[idx])));
        chk("sweep_rem", 32'(rem),
            32'(vals[idx] - isqrt(vals[idx]) * isqrt(vals[idx])));
        if (last >= 0) chk("sweep_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        wt   = 0;
        idx++;
        if (idx < vals.size()) radicand = 16'(vals[idx]);
      end else begin
        wt++;
        if (wt > 30) begin
          chk("sweep_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
